// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
//   Writeback scheduler for the Y86 SEQ register file. Takes one writeback
//   request per instruction and serialises its two possible writes onto the
//   single register-file write port. The E write (valE) goes first and the
//   M write (valM) follows. The block also flags read-after-write hazards
//   for decode and supports a halt/drain sequence.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset
//   wb_valid   : writeback request valid
//   wb_ready   : a request can be accepted this cycle
//   dstE/valE  : ALU-result destination and value
//   dstM/valM  : memory-result destination and value
//   halt       : processor halted; stop accepting requests (sticky)
//   rf_wr_en   : register-file write enable
//   rf_wr_num  : register-file write address
//   rf_wr_val  : register-file write data
//   srcA/srcB  : decode read-port register numbers
//   raw_stall  : decode must stall on a pending write to srcA/srcB
//   busy       : a write sequence is in progress
//   drained    : halted and nothing left to write
//   wr_count   : committed-write counter, saturating
module regfile_wb_sequencer #(
  parameter int                DATA_W = 64,
  parameter int                REG_W  = 4,
  parameter logic [REG_W-1:0]  RNONE  = {REG_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_W-1:0]  dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [REG_W-1:0]  dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              halt,
  output logic              rf_wr_en,
  output logic [REG_W-1:0]  rf_wr_num,
  output logic [DATA_W-1:0] rf_wr_val,
  input  logic [REG_W-1:0]  srcA,
  input  logic [REG_W-1:0]  srcB,
  output logic              raw_stall,
  output logic              busy,
  output logic              drained,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  state_t            first_st;
  logic [REG_W-1:0]  dste_q;
  logic [REG_W-1:0]  dstm_q;
  logic [DATA_W-1:0] vale_q;
  logic [DATA_W-1:0] valm_q;
  logic              halt_q;
  logic              final_wr;
  logic              accept;
  logic              pend_e;
  logic              pend_m;

  // The last write of the current request: a new request may be accepted
  // here and start in the very next cycle without a bubble.
  assign final_wr = (state == WR_M) || ((state == WR_E) && (dstm_q == RNONE));
  assign wb_ready = !halt_q && ((state == IDLE) || final_wr);
  assign accept   = wb_valid && wb_ready;
  assign busy     = (state != IDLE);
  assign drained  = halt_q && (state == IDLE);

  // First state of an incoming request; a request with no destinations is
  // consumed without producing any write.
  assign first_st = (dstE != RNONE) ? WR_E :
                    (dstM != RNONE) ? WR_M : IDLE;

  // Write port decodes only state and latched values, so nothing on the
  // request inputs can reach the register file in the same cycle.
  // NOTE: every always_comb output gets a default first; a branch that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    rf_wr_en  = 1'b0;
    rf_wr_num = RNONE;
    rf_wr_val = '0;
    state_n   = IDLE;
    unique case (state)
      IDLE: begin
        state_n = accept ? first_st : IDLE;
      end
      WR_E: begin
        rf_wr_en  = 1'b1;
        rf_wr_num = dste_q;
        rf_wr_val = vale_q;
        if (dstm_q != RNONE) state_n = WR_M;
        else                 state_n = accept ? first_st : IDLE;
      end
      WR_M: begin
        rf_wr_en  = 1'b1;
        rf_wr_num = dstm_q;
        rf_wr_val = valm_q;
        state_n   = accept ? first_st : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A write is still pending for a register until the cycle that commits it
  // has ended. RNONE is never a hazard.
  assign pend_e = (state == WR_E) && (dste_q != RNONE);
  assign pend_m = ((state == WR_E) || (state == WR_M)) && (dstm_q != RNONE);

  always_comb begin
    raw_stall = 1'b0;
    if (srcA != RNONE &&
        ((pend_e && srcA == dste_q) || (pend_m && srcA == dstm_q)))
      raw_stall = 1'b1;
    if (srcB != RNONE &&
        ((pend_e && srcB == dste_q) || (pend_m && srcB == dstm_q)))
      raw_stall = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register here samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the request latches are reset as well; a reset that lands
      // mid-sequence must discard pending writes instead of leaving stale
      // addresses behind for the hazard compare.
      state    <= IDLE;
      dste_q   <= RNONE;
      dstm_q   <= RNONE;
      vale_q   <= '0;
      valm_q   <= '0;
      halt_q   <= 1'b0;
      wr_count <= '0;
    end else begin
      state <= state_n;
      if (halt) halt_q <= 1'b1;
      if (rf_wr_en && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (accept) begin
        dste_q <= dstE;
        vale_q <= valE;
        dstm_q <= dstM;
        valm_q <= valM;
      end
    end
  end

endmodule
